// File: rtl/lpc_coef_bank_ctrl_pkg.sv
// Shared constants, the state type and the index-to-one-hot helper for the
// LPC coefficient bank sequencer.
package lpc_bank_pkg;

    localparam int NWORDS = 9;   // words per frame, equals bank depth
    localparam int DW     = 32;  // data width
    localparam int IW     = 4;   // index width, 2**IW >= NWORDS

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    // Indices at or above NWORDS produce an all-zero vector, which lets callers
    // detect an out-of-range index with a reduction OR.
    function automatic logic [NWORDS-1:0] idx_to_onehot(input logic [IW-1:0] idx);
        logic [NWORDS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx == IW'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/lpc_coef_bank_ctrl_if.sv
// Producer stream and consumer read handshake between the LPC pipeline and
// the coefficient bank sequencer.
interface lpc_coef_bank_ctrl_if;
    import lpc_bank_pkg::*;

    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          rd_req;
    logic [IW-1:0] rd_idx;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          rd_err;

    // Pipeline side: producer and consumer.
    modport master (
        output start, in_valid, in_data, rd_req, rd_idx,
        input  in_ready, rd_ack, rd_data, rd_err
    );

    // Sequencer side.
    modport slave (
        input  start, in_valid, in_data, rd_req, rd_idx,
        output in_ready, rd_ack, rd_data, rd_err
    );

endinterface

// File: rtl/lpc_onehot_dec.sv
// Index to one-hot decoder with enable; all-zero when disabled or when the
// index is outside the bank.
module lpc_onehot_dec
    import lpc_bank_pkg::*;
(
    input  logic              en,
    input  logic [IW-1:0]     idx,
    output logic [NWORDS-1:0] oh
);

    // Gate the decoded index with the enable.
    always_comb begin
        oh = '0;
        if (en) begin
            oh = idx_to_onehot(idx);
        end
    end

endmodule

// File: rtl/lpc_coef_bank_ctrl.sv
// Sequencer for the 9x32 coefficient register bank: loads one frame of
// autocorrelation words in index order, then serves indexed reads with a
// fixed one-cycle latency.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | no valid frame; waits for start, reads are rejected
//  LOAD  | accepting words 0..NWORDS-1 in order; start is ignored
//  READY | full frame held; reads served, start begins a new frame
module lpc_coef_bank_ctrl
    import lpc_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    lpc_coef_bank_ctrl_if.slave  bus,
    output logic                 busy,
    output logic                 full,
    output logic [NWORDS-1:0]    wsel,
    output logic [DW-1:0]        din,
    output logic [NWORDS-1:0]    rsel,
    input  logic [DW-1:0]        dout
);

    localparam logic [1:0]    ST_IDLE  = 2'(IDLE);
    localparam logic [1:0]    ST_LOAD  = 2'(LOAD);
    localparam logic [1:0]    ST_READY = 2'(READY);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    logic [1:0]        state_q;
    logic [IW-1:0]     wptr_q;
    logic [NWORDS-1:0] rsel_q;
    logic              accept;
    logic              rd_en;
    logic [NWORDS-1:0] rd_oh;
    logic              rd_hit;

    lpc_onehot_dec u_wdec (
        .en  (accept),
        .idx (wptr_q),
        .oh  (wsel)
    );

    // Decoder output is zero for out-of-range indices and outside READY.
    lpc_onehot_dec u_rdec (
        .en  (rd_en),
        .idx (bus.rd_idx),
        .oh  (rd_oh)
    );

    // Handshake qualifiers and bank drive; rsel falls back to the last good
    // select so the bank's read mux always sees a one-hot code.
    always_comb begin
        accept       = (state_q == ST_LOAD) && bus.in_valid;
        rd_en        = (state_q == ST_READY) && bus.rd_req;
        rd_hit       = |rd_oh;
        rsel         = rd_hit ? rd_oh : rsel_q;
        din          = bus.in_data;
        bus.in_ready = (state_q == ST_LOAD);
        busy         = (state_q == ST_LOAD);
        full         = (state_q == ST_READY);
    end

    // Frame load sequencing and write pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_LOAD;
                        wptr_q  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (wptr_q == LAST_IDX) begin
                            state_q <= ST_READY;
                            wptr_q  <= '0;
                        end else begin
                            wptr_q  <= wptr_q + 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (bus.start) begin
                        state_q <= ST_LOAD;
                        wptr_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    wptr_q  <= '0;
                end
            endcase
        end
    end

    // Read response: every request is acknowledged one cycle later, either
    // with bank data or with an error and zeroed data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rd_ack  <= 1'b0;
            bus.rd_err  <= 1'b0;
            bus.rd_data <= '0;
            rsel_q      <= NWORDS'(1);
        end else begin
            bus.rd_ack <= bus.rd_req;
            if (bus.rd_req) begin
                if (rd_hit) begin
                    rsel_q      <= rd_oh;
                    bus.rd_data <= dout;
                    bus.rd_err  <= 1'b0;
                end else begin
                    bus.rd_data <= '0;
                    bus.rd_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lpc_coef_bank_ctrl.sv
// Bench for the coefficient bank sequencer with a behavioural 9x32 bank.
// Stimulus pushes expected writes and read responses into queues; a monitor
// on the falling edge pops and compares whenever the DUT writes or acks.
module tb_lpc_coef_bank_ctrl;
    import lpc_bank_pkg::*;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rd_exp_t;

    typedef struct {
        logic [8:0]  sel;
        logic [31:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy, full;
    logic [8:0]  wsel, rsel;
    logic [31:0] din, dout;
    logic [31:0] mem [9];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_count = 0;
    int wr_base;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];

    lpc_coef_bank_ctrl_if bus();

    lpc_coef_bank_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .full  (full),
        .wsel  (wsel),
        .din   (din),
        .rsel  (rsel),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    // Bank model: one-hot write on the clock, combinational one-hot read.
    always @(posedge clk) begin
        for (int i = 0; i < 9; i++) begin
            if (wsel[i]) mem[i] <= din;
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < 9; i++) begin
            if (rsel[i]) dout = dout | mem[i];
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx, input logic err, input logic [31:0] data,
                      input logic [8:0] exp_rsel);
        rd_exp_t e;
        bus.rd_req = 1'b1;
        bus.rd_idx = idx;
        e.due  = cyc + 1;
        e.err  = err;
        e.data = data;
        rd_q.push_back(e);
        @(negedge clk);
        check("rsel_during_req", rsel, exp_rsel);
        tick();
        bus.rd_req = 1'b0;
    endtask

    task automatic stream(input logic [31:0] base, input logic gaps, input int n, input logic last_rd);
        int          i;
        logic        v;
        logic [8:0]  one;
        wr_exp_t     w;
        rd_exp_t     e;
        i   = 0;
        one = 9'd1;
        for (int c = 0; c < 40 && i < n; c++) begin
            v = !gaps || (c % 2 == 0);
            bus.in_valid = v;
            bus.in_data  = v ? base + 32'(i) : 32'hDEAD_0000 + 32'(c);
            if (v) begin
                w.sel  = one << i;
                w.data = base + 32'(i);
                wr_q.push_back(w);
            end
            if (last_rd && v && i == n - 1) begin
                bus.rd_req = 1'b1;
                bus.rd_idx = 4'd0;
                e.due  = cyc + 1;
                e.err  = 1'b1;
                e.data = 32'h0;
                rd_q.push_back(e);
            end
            @(negedge clk);
            if (!v) begin
                check("gap_wsel", wsel, 9'h000);
                check("gap_in_ready", bus.in_ready, 1'b1);
            end
            tick();
            bus.rd_req = 1'b0;
            if (v) i++;
        end
        bus.in_valid = 1'b0;
    endtask

    // Monitor: compares every bank write and every read ack with the queues.
    initial forever begin
        wr_exp_t w;
        rd_exp_t e;
        @(negedge clk);
        if (reset) begin
            check("rsel_onehot", $onehot(rsel), 1'b1);
            if (bus.rd_ack) begin
                check("ack_pending", rd_q.size() != 0, 1'b1);
                if (rd_q.size() != 0) begin
                    e = rd_q.pop_front();
                    check("ack_cycle", cyc, e.due);
                    check("rd_err", bus.rd_err, e.err);
                    check("rd_data", bus.rd_data, e.data);
                end
            end
            if (wsel != 9'h000) begin
                wr_count++;
                check("wsel_onehot", $onehot(wsel), 1'b1);
                check("write_pending", wr_q.size() != 0, 1'b1);
                if (wr_q.size() != 0) begin
                    w = wr_q.pop_front();
                    check("wsel", wsel, w.sel);
                    check("din", din, w.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.rd_req   = 1'b0;
        bus.rd_idx   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_wsel", wsel, 9'h000);
        check("rst_rsel", rsel, 9'h001);
        check("rst_rd_ack", bus.rd_ack, 1'b0);
        check("rst_rd_err", bus.rd_err, 1'b0);
        check("rst_rd_data", bus.rd_data, 32'h0);
        reset = 1'b1;
        tick();

        // Read while IDLE is rejected; rsel stays at its reset code.
        rd(4'd0, 1'b1, 32'h0, 9'h001);

        // Frame A, continuous stream, read on the completing edge rejected.
        do_start();
        check("load_busy", busy, 1'b1);
        check("load_in_ready", bus.in_ready, 1'b1);
        wr_base = wr_count;
        stream(32'hA0, 1'b0, 9, 1'b1);
        check("a_full", full, 1'b1);
        check("a_busy", busy, 1'b0);
        check("a_in_ready", bus.in_ready, 1'b0);
        check("a_writes", wr_count - wr_base, 9);

        // Back-to-back reads of the whole frame.
        for (int i = 0; i < 9; i++) begin
            rd(4'(i), 1'b0, 32'hA0 + 32'(i), 9'(1) << i);
        end

        // Out-of-range reads: error, zero data, rsel holds.
        rd(4'd9, 1'b1, 32'h0, 9'h100);
        rd(4'd15, 1'b1, 32'h0, 9'h100);
        tick();
        check("rsel_hold", rsel, 9'h100);

        // start and read together: old data returned, new load begins.
        bus.start = 1'b1;
        rd(4'd3, 1'b0, 32'hA3, 9'h008);
        bus.start = 1'b0;
        check("restart_busy", busy, 1'b1);
        check("restart_full", full, 1'b0);
        wr_base = wr_count;
        stream(32'hC0, 1'b0, 9, 1'b0);
        check("c_writes", wr_count - wr_base, 9);
        check("c_full", full, 1'b1);
        rd(4'd0, 1'b0, 32'hC0, 9'h001);
        rd(4'd5, 1'b0, 32'hC5, 9'h020);
        rd(4'd8, 1'b0, 32'hC8, 9'h100);

        // Gapped stream; a read during LOAD is rejected.
        do_start();
        rd(4'd2, 1'b1, 32'h0, 9'h100);
        wr_base = wr_count;
        stream(32'hD0, 1'b1, 9, 1'b0);
        check("d_writes", wr_count - wr_base, 9);
        check("d_full", full, 1'b1);
        for (int i = 0; i < 9; i++) begin
            rd(4'(i), 1'b0, 32'hD0 + 32'(i), 9'(1) << i);
        end

        // Reset after four words discards the partial frame.
        do_start();
        stream(32'hE0, 1'b0, 4, 1'b0);
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hE4;
        #1;
        check("midrst_wsel", wsel, 9'h000);
        check("midrst_in_ready", bus.in_ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_full", full, 1'b0);
        check("midrst_rsel", rsel, 9'h001);
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        do_start();
        wr_base = wr_count;
        stream(32'hB0, 1'b0, 9, 1'b0);
        check("b_writes", wr_count - wr_base, 9);
        for (int i = 0; i < 9; i++) begin
            rd(4'(i), 1'b0, 32'hB0 + 32'(i), 9'(1) << i);
        end

        repeat (3) tick();
        check("rd_queue_drained", rd_q.size(), 0);
        check("wr_queue_drained", wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
